// File: rtl/pic_host_bus_master.sv
// CPU-side bus master for an 8259A-style PIC: register access takes 3+PULSE_CYCLES clocks to rsp_valid, INTA takes 2*PULSE+GAP+1 to vec_valid.
// Backpressure: cmd_ready is low whenever the master is busy or an enabled interrupt is pending; started sequences always run to completion.
module pic_host_bus_master #(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  input  logic       int_en,
  input  logic       INT,
  output logic       vec_valid,
  output logic [7:0] vec_data,
  output logic       busy,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       INTA_n,
  output logic       A0,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] d_in
);

  localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, INTA1, GAP, INTA2, DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last;
  logic          wr_q;
  logic [7:0]    rd_byte;

  assign last      = (cnt == CW'(1));
  assign busy      = (state != IDLE);
  assign cmd_ready = (state == IDLE) && !(int_en && INT) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      rd_byte   <= 8'h00;
      CS_n      <= 1'b1;
      RD_n      <= 1'b1;
      WR_n      <= 1'b1;
      INTA_n    <= 1'b1;
      A0        <= 1'b0;
      d_out     <= 8'h00;
      d_oe      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      vec_valid <= 1'b0;
      vec_data  <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      vec_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Interrupt acknowledge wins over a waiting command.
          if (int_en && INT) begin
            state  <= INTA1;
            INTA_n <= 1'b0;
            cnt    <= CW'(PULSE_CYCLES);
          end else if (cmd_valid) begin
            state <= SETUP;
            wr_q  <= cmd_write;
            CS_n  <= 1'b0;
            A0    <= cmd_a0;
            d_oe  <= cmd_write;
            d_out <= cmd_write ? cmd_data : 8'h00;
          end
        end
        SETUP: begin
          state <= STROBE;
          cnt   <= CW'(PULSE_CYCLES);
          if (wr_q) WR_n <= 1'b0;
          else      RD_n <= 1'b0;
        end
        STROBE: begin
          if (last) begin
            state <= HOLD;
            RD_n  <= 1'b1;
            WR_n  <= 1'b1;
            if (!wr_q) rd_byte <= d_in;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HOLD: begin
          state     <= IDLE;
          CS_n      <= 1'b1;
          d_oe      <= 1'b0;
          d_out     <= 8'h00;
          rsp_valid <= 1'b1;
          rsp_data  <= wr_q ? 8'h00 : rd_byte;
        end
        INTA1: begin
          if (last) begin
            state  <= GAP;
            INTA_n <= 1'b1;
            cnt    <= CW'(GAP_CYCLES);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        GAP: begin
          if (last) begin
            state  <= INTA2;
            INTA_n <= 1'b0;
            cnt    <= CW'(PULSE_CYCLES);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        INTA2: begin
          if (last) begin
            state     <= DONE;
            INTA_n    <= 1'b1;
            vec_data  <= d_in;
            vec_valid <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_host_bus_master.sv
// Bench for pic_host_bus_master: directed protocol timing plus randomized access/acknowledge mix against a register-file PIC model.
module tb_pic_host_bus_master;
  localparam int P = 2;
  localparam int G = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic       cmd_a0 = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       int_en = 1'b1;
  logic       INT = 1'b0;
  logic       vec_valid;
  logic [7:0] vec_data;
  logic       busy;
  logic       CS_n, RD_n, WR_n, INTA_n, A0;
  logic [7:0] d_out;
  logic       d_oe;
  logic [7:0] d_in = 8'h00;

  always #5 clk = ~clk;

  pic_host_bus_master #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_a0(cmd_a0), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .int_en(int_en), .INT(INT),
    .vec_valid(vec_valid), .vec_data(vec_data), .busy(busy),
    .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n), .INTA_n(INTA_n), .A0(A0),
    .d_out(d_out), .d_oe(d_oe), .d_in(d_in)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_rsp[$];
  logic [7:0] exp_vec[$];
  logic [7:0] ref_mem[2] = '{8'h00, 8'h00};
  logic [7:0] pic_mem[2] = '{8'h00, 8'h00};
  logic [7:0] pic_vec = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // PIC side: two registers selected by A0, vector returned while INTA_n is low, junk otherwise.
  always @(negedge clk) begin
    if (!WR_n) pic_mem[A0] = d_out;
    if (!RD_n)        d_in = pic_mem[A0];
    else if (!INTA_n) d_in = pic_vec;
    else              d_in = 8'($urandom);
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    int lows;
    if (rsp_valid) begin
      if (exp_rsp.size() == 0) chk("rsp_unexpected", 1, 0);
      else chk("rsp_data", rsp_data, exp_rsp.pop_front());
    end
    if (vec_valid) begin
      if (exp_vec.size() == 0) chk("vec_unexpected", 1, 0);
      else chk("vec_data", vec_data, exp_vec.pop_front());
    end
    lows = int'(!RD_n) + int'(!WR_n) + int'(!INTA_n);
    chk("strobe_excl", {31'b0, (lows <= 1) && (!d_oe || (!CS_n && INTA_n))}, 1);
  end

  task automatic track_cmd(input logic w, input logic a0, input logic [7:0] d);
    logic cs_low, st_low;
    for (int k = 1; k <= P + 3; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
      cs_low = (k <= P + 2);
      st_low = (k >= 2) && (k <= P + 1);
      chk($sformatf("cmd_bus k=%0d w=%0d", k, w),
          {CS_n, RD_n, WR_n, INTA_n, d_oe, rsp_valid},
          {!cs_low, !(st_low && !w), !(st_low && w), 1'b1, w && cs_low, k == P + 3});
      if (cs_low) chk("cmd_a0", A0, a0);
      if (cs_low && w) chk("cmd_dout", d_out, d);
    end
  endtask

  task automatic issue(input logic w, input logic a0, input logic [7:0] d,
                       input bit timed, input bit want_rsp);
    int n = 0;
    cmd_write = w; cmd_a0 = a0; cmd_data = d; cmd_valid = 1'b1;
    #1;
    while (!cmd_ready && n < 40) begin
      @(negedge clk); #1; n++;
    end
    if (!cmd_ready) begin
      chk("cmd_accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    if (want_rsp) exp_rsp.push_back(w ? 8'h00 : ref_mem[a0]);
    if (w) ref_mem[a0] = d;
    @(posedge clk);
    if (timed) track_cmd(w, a0, d);
    else begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic raise_int(input logic [7:0] v);
    pic_vec = v;
    exp_vec.push_back(v);
    int_en = 1'b1;
    INT = 1'b1;
    #1;
    chk("ready_masked_by_int", cmd_ready, 0);
  endtask

  task automatic int_seq(input int drop_k);
    logic low;
    for (int k = 1; k <= 2 * P + G + 1; k++) begin
      @(negedge clk);
      low = (k <= P) || (k >= P + G + 1 && k <= 2 * P + G);
      chk($sformatf("inta_bus k=%0d", k),
          {CS_n, RD_n, WR_n, INTA_n, d_oe, vec_valid},
          {1'b1, 1'b1, 1'b1, !low, 1'b0, k == 2 * P + G + 1});
      if (k == drop_k) INT = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    repeat (3) @(negedge clk);
    chk("rst_strobes", {CS_n, RD_n, WR_n, INTA_n}, 4'hF);
    chk("rst_bus", {A0, d_oe, d_out}, 10'h000);
    chk("rst_valids", {rsp_valid, vec_valid, busy}, 3'b000);
    chk("rst_data", {rsp_data, vec_data}, 16'h0000);
    chk("rst_ready", cmd_ready, 0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", cmd_ready, 1);

    // ICW1 write, then a read of a register loaded with 0xA5.
    issue(1'b1, 1'b0, 8'h13, 1, 1);
    issue(1'b1, 1'b1, 8'hA5, 1, 1);
    issue(1'b0, 1'b1, 8'h00, 1, 1);

    // Plain acknowledge.
    raise_int(8'h48);
    int_seq(1);

    // Interrupt and command together: acknowledge first, command afterwards.
    @(negedge clk);
    cmd_write = 1'b1; cmd_a0 = 1'b1; cmd_data = 8'h5C; cmd_valid = 1'b1;
    raise_int(8'h21);
    int_seq(1);
    issue(1'b1, 1'b1, 8'h5C, 1, 1);

    // INT drops during GAP: second pulse still runs.
    @(negedge clk);
    raise_int(8'h33);
    int_seq(P + 1);

    // INT held: second sequence follows after a single idle cycle.
    @(negedge clk);
    raise_int(8'h40);
    int_seq(0);
    pic_vec = 8'h41;
    exp_vec.push_back(8'h41);
    @(negedge clk);
    chk("b2b_idle", {busy, INTA_n}, 2'b01);
    int_seq(1);

    // Acknowledge disabled: INT ignored, commands still flow.
    @(negedge clk);
    int_en = 1'b0;
    INT = 1'b1;
    #1;
    chk("ready_int_disabled", cmd_ready, 1);
    repeat (4) begin
      @(negedge clk);
      chk("no_inta_when_disabled", {INTA_n, busy}, 2'b10);
    end
    issue(1'b0, 1'b0, 8'h00, 1, 1);
    INT = 1'b0;
    int_en = 1'b1;

    // Reset in the middle of a write strobe.
    @(negedge clk);
    issue(1'b1, 1'b0, 8'h7E, 0, 0);
    @(negedge clk);
    chk("wr_strobe_before_rst", WR_n, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_bus", {CS_n, RD_n, WR_n, INTA_n, d_oe, busy, rsp_valid}, 7'b1111000);
    reset = 1'b0;
    issue(1'b0, 1'b0, 8'h00, 1, 1);

    // Randomized mix.
    for (int i = 0; i < 60; i++) begin
      repeat (1 + $urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        v = 8'($urandom);
        raise_int(v);
        int_seq(int'($urandom_range(1, 2 * P + G + 1)));
      end else begin
        issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 1, 1);
      end
    end

    repeat (6) @(negedge clk);
    chk("rsp_queue_drained", exp_rsp.size(), 0);
    chk("vec_queue_drained", exp_vec.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
